// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter. It requests the bus from the CPU
// (BR / BG / BGACK protocol) on behalf of the winning requester.
module bus_arbiter #(
  parameter int unsigned BG_TIMEOUT = 255,
  parameter int unsigned MAX_TENURE = 1023
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET_n_IN,
  input  logic       RUN_IN,
  input  logic       REQ0_IN,
  input  logic       REQ1_IN,
  input  logic       BG_IN,
  input  logic       AS_IN,
  input  logic       DTACK_IN,
  output logic       BR,
  output logic       BGACK,
  output logic       GNT0,
  output logic       GNT1,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic [2:0] state_o
);

  // Handshake: BR is raised while a request is pending. Ownership is taken
  // once BG_IN has been seen and the bus is quiet (AS_IN=0, DTACK_IN=0).
  // On that edge BR falls and BGACK rises.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQUEST  = 3'd1,
    ST_WAIT_BUS = 3'd2,
    ST_OWNED    = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  localparam logic [7:0] BG_LAST  = 8'(BG_TIMEOUT - 1);
  localparam bit         TEN_EN   = (MAX_TENURE != 0);
  localparam logic [9:0] TEN_LAST = TEN_EN ? 10'(MAX_TENURE - 1) : 10'd0;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [9:0] ten_cnt_q, ten_cnt_d;
  logic       pulse_d;
  logic       br_q, br_d;
  logic       bgack_q, bgack_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       busy_q, busy_d;
  logic       timeout_q;

  logic req_own;
  logic bg_expired;
  logic ten_expired;

  assign req_own     = owner_q ? REQ1_IN : REQ0_IN;
  assign bg_expired  = (wait_cnt_q == BG_LAST);
  assign ten_expired = TEN_EN && (ten_cnt_q >= TEN_LAST);

  always_ff @(posedge CPUCLK_IN) begin
    if (!RESET_n_IN) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;  // requester 0 wins the first tie
      wait_cnt_q <= 8'd0;
      ten_cnt_q  <= 10'd0;
      br_q       <= 1'b0;
      bgack_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      ten_cnt_q  <= ten_cnt_d;
      br_q       <= br_d;
      bgack_q    <= bgack_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      busy_q     <= busy_d;
      timeout_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (RUN_IN && (REQ0_IN || REQ1_IN)) begin
          state_d = ST_REQUEST;
          owner_d = (REQ0_IN && REQ1_IN) ? ~last_q : REQ1_IN;
        end
      end
      ST_REQUEST: begin
        // Withdrawal beats BG_IN; BG_IN beats the abort timer.
        if (!req_own || !RUN_IN) begin
          state_d = ST_IDLE;
        end else if (BG_IN) begin
          state_d = ST_WAIT_BUS;
        end else if (bg_expired) begin
          state_d = ST_IDLE;
          pulse_d = 1'b1;
          last_d  = owner_q;
        end
      end
      ST_WAIT_BUS: begin
        if (!req_own || !RUN_IN) begin
          state_d = ST_IDLE;
        end else if (!AS_IN && !DTACK_IN) begin
          state_d = ST_OWNED;
          last_d  = owner_q;
        end
      end
      ST_OWNED: begin
        // A voluntary release masks a coincident tenure expiry.
        if (!req_own) begin
          state_d = ST_RELEASE;
        end else if (ten_expired && !AS_IN) begin
          state_d = ST_RELEASE;
          pulse_d = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    wait_cnt_d = wait_cnt_q;
    ten_cnt_d  = ten_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
      ten_cnt_d  = 10'd0;
    end else begin
      if (state_q == ST_REQUEST && wait_cnt_q != 8'hFF)
        wait_cnt_d = wait_cnt_q + 8'd1;
      if (state_q == ST_OWNED && ten_cnt_q != 10'h3FF)
        ten_cnt_d = ten_cnt_q + 10'd1;
    end
  end

  always_comb begin
    br_d    = (state_d == ST_REQUEST) || (state_d == ST_WAIT_BUS);
    bgack_d = (state_d == ST_OWNED);
    gnt0_d  = (state_d == ST_OWNED) && !owner_d;
    gnt1_d  = (state_d == ST_OWNED) && owner_d;
    busy_d  = (state_d != ST_IDLE);
  end

  assign BR      = br_q;
  assign BGACK   = bgack_q;
  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios push time-stamped expected output
// words; a monitor pops one entry each time the observed output word changes.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, run, req0, req1, bg, as_s, dtack;
  logic       br, bgack, gnt0, gnt1, busy, tmo;
  logic [2:0] st;

  always #5 clk = ~clk;

  bus_arbiter #(.BG_TIMEOUT(255), .MAX_TENURE(16)) dut (
    .CPUCLK_IN(clk), .RESET_n_IN(rst_n), .RUN_IN(run),
    .REQ0_IN(req0), .REQ1_IN(req1), .BG_IN(bg), .AS_IN(as_s), .DTACK_IN(dtack),
    .BR(br), .BGACK(bgack), .GNT0(gnt0), .GNT1(gnt1), .BUSY(busy),
    .TIMEOUT(tmo), .state_o(st)
  );

  // Output word: {state, BR, BGACK, GNT0, GNT1, BUSY, TIMEOUT}
  localparam logic [8:0] W_IDLE   = {3'd0, 6'b000000};
  localparam logic [8:0] W_IDLETO = {3'd0, 6'b000001};
  localparam logic [8:0] W_REQ    = {3'd1, 6'b100010};
  localparam logic [8:0] W_WAIT   = {3'd2, 6'b100010};
  localparam logic [8:0] W_OWN0   = {3'd3, 6'b011010};
  localparam logic [8:0] W_OWN1   = {3'd3, 6'b010110};
  localparam logic [8:0] W_REL    = {3'd4, 6'b000010};
  localparam logic [8:0] W_RELTO  = {3'd4, 6'b000011};

  logic [8:0]  act_w;
  assign act_w = {st, br, bgack, gnt0, gnt1, busy, tmo};

  int          cyc = 0;
  int          base = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          rst_done = 1'b0;
  bit          tb_done = 1'b0;
  logic [40:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic expect_at(input int offs, input logic [8:0] w);
    exp_q.push_back({32'(base + offs), w});
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic [8:0]  prev_w;
    logic [40:0] e;
    wait (rst_done);
    @(negedge clk);
    n_vec++;
    if (act_w !== W_IDLE) begin
      n_bad++;
      $display("FAIL reset_state actual=%b required=%b", act_w, W_IDLE);
    end
    prev_w = act_w;
    while (!tb_done) begin
      @(negedge clk);
      n_vec++;
      if ((br && bgack) || (gnt0 && gnt1)) begin
        n_bad++;
        $display("FAIL invariant cyc=%0d actual=%b required=no BR&BGACK, no GNT0&GNT1",
                 cyc, act_w);
      end
      if (act_w !== prev_w) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d actual=%b required=no change", cyc, act_w);
        end else begin
          e = exp_q.pop_front();
          if (e[40:9] != 32'(cyc) || e[8:0] !== act_w) begin
            n_bad++;
            $display("FAIL output_event actual=%b@%0d required=%b@%0d",
                     act_w, cyc, e[8:0], e[40:9]);
          end
        end
        prev_w = act_w;
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_event actual=none required=%b@%0d", e[8:0], e[40:9]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin : driver
    rst_n = 1'b0; run = 1'b1; req0 = 1'b0; req1 = 1'b0;
    bg = 1'b0; as_s = 1'b0; dtack = 1'b0;
    step(3);
    rst_done = 1'b1;
    rst_n = 1'b1;
    step(2);

    // Single grant to requester 0 with release
    start_test();
    expect_at(1, W_REQ); expect_at(4, W_WAIT); expect_at(5, W_OWN0);
    expect_at(11, W_REL); expect_at(12, W_IDLE);
    req0 = 1'b1;
    step(3); bg = 1'b1;
    step(7); req0 = 1'b0; bg = 1'b0;
    step(4);

    // Both held: tenure expiry then alternation
    start_test();
    expect_at(1, W_REQ); expect_at(2, W_WAIT); expect_at(3, W_OWN1);
    expect_at(19, W_RELTO); expect_at(20, W_IDLE);
    expect_at(21, W_REQ); expect_at(22, W_WAIT); expect_at(23, W_OWN0);
    expect_at(26, W_REL); expect_at(27, W_IDLE);
    req0 = 1'b1; req1 = 1'b1; bg = 1'b1;
    step(25); req0 = 1'b0; req1 = 1'b0; bg = 1'b0;
    step(4);

    // BG abort for requester 1 after 255 cycles of BR
    start_test();
    expect_at(1, W_REQ); expect_at(256, W_IDLETO); expect_at(257, W_IDLE);
    req1 = 1'b1;
    step(256); req1 = 1'b0;
    step(3);

    // Tie after abort, RUN abort in WAIT_BUS, DTACK gating, deferred expiry
    start_test();
    expect_at(1, W_REQ); expect_at(2, W_WAIT); expect_at(5, W_IDLE);
    expect_at(6, W_REQ); expect_at(7, W_WAIT); expect_at(9, W_OWN0);
    expect_at(28, W_RELTO); expect_at(29, W_IDLE);
    req0 = 1'b1; req1 = 1'b1; bg = 1'b1; as_s = 1'b1;
    step(4); run = 1'b0;
    step(1); run = 1'b1;
    step(2); as_s = 1'b0; dtack = 1'b1;
    step(1); dtack = 1'b0;
    step(2); req1 = 1'b0;
    step(1); req1 = 1'b1;
    step(1); run = 1'b0;
    step(1); req1 = 1'b0;
    step(2); run = 1'b1;
    step(5); as_s = 1'b1;
    step(7); as_s = 1'b0;
    step(1); req0 = 1'b0; bg = 1'b0;
    step(3);

    // Withdrawal in REQUEST
    start_test();
    expect_at(1, W_REQ); expect_at(3, W_IDLE);
    req1 = 1'b1;
    step(2); req1 = 1'b0;
    step(3);

    // BG on the last wait cycle wins; REQ drop coincident with expiry
    start_test();
    expect_at(1, W_REQ); expect_at(256, W_WAIT); expect_at(257, W_OWN0);
    expect_at(273, W_REL); expect_at(274, W_IDLE);
    req0 = 1'b1;
    step(255); bg = 1'b1;
    step(2); bg = 1'b0;
    step(15); req0 = 1'b0;
    step(4);

    // Reset mid-ownership, then tie goes to requester 0
    start_test();
    expect_at(1, W_REQ); expect_at(2, W_WAIT); expect_at(3, W_OWN0);
    expect_at(6, W_IDLE);
    expect_at(7, W_REQ); expect_at(8, W_WAIT); expect_at(9, W_OWN0);
    expect_at(11, W_REL); expect_at(12, W_IDLE);
    req0 = 1'b1; bg = 1'b1;
    step(5); rst_n = 1'b0; req1 = 1'b1;
    step(1); rst_n = 1'b1;
    step(4); req0 = 1'b0; req1 = 1'b0; bg = 1'b0;
    step(4);

    tb_done = 1'b1;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter BG_TIMEOUT, default 255: max cycles in REQUEST awaiting BG_IN before abort; range 1..255, 8-bit counter.
REQ-002 SHALL have parameter MAX_TENURE, default 1023: max cycles a requester holds the bus before forced release; 0 disables; 10-bit counter.
REQ-003 SHALL have CPUCLK_IN, input, 1: sole clock, rising edge; one clock, reset synchronous and active-low.
REQ-004 SHALL have RESET_n_IN, input, 1: synchronous active-low reset.
REQ-005 SHALL have RUN_IN, input, 1: CPU running; new requests accepted only when high.
REQ-006 SHALL have REQ0_IN and REQ1_IN, inputs, 1 each: active-high bus requests from requester 0 and requester 1, level-held until done.
REQ-007 SHALL have BG_IN, AS_IN and DTACK_IN, inputs, 1 each: active-high bus grant, address strobe and data acknowledge.
REQ-008 SHALL have BR and BGACK, outputs, 1 each: active-high bus request and bus-grant-acknowledge; the top level inverts these to BR_n and BGACK_n.
REQ-009 SHALL have GNT0 and GNT1, outputs, 1 each: requester owns the bus; the two are mutually exclusive.
REQ-010 SHALL have BUSY, output, 1: state is not IDLE.
REQ-011 SHALL have TIMEOUT, output, 1: one-cycle pulse on BG abort or tenure expiry.

Function
REQ-012 SHALL implement the states IDLE, REQUEST, WAIT_BUS, OWNED and RELEASE, all registered; all outputs SHALL be driven from registers.
REQ-013 IDLE: when RUN_IN is high and any REQ is high, the arbiter SHALL latch the winner and go to REQUEST; BR SHALL be 1 on the next cycle.
REQ-014 Winner selection SHALL be round-robin: if both REQs are high, pick the requester not served last; if one is high, pick it.
REQ-015 The last-served pointer SHALL update on entry to OWNED and on BG timeout, in which case it points to the aborted requester.
REQ-016 REQUEST: BR=1 and the wait counter increments each cycle. If BG_IN=1, go to WAIT_BUS.
REQ-017 REQUEST: if the counter reaches BG_TIMEOUT without BG_IN, then BR=0, pulse TIMEOUT, and go to IDLE.
REQ-018 WAIT_BUS: BR=1. When AS_IN=0 and DTACK_IN=0 in the same cycle, go to OWNED, and on that edge set BGACK=1, BR=0, and the latched GNTx=1.
REQ-019 OWNED: BGACK=1 and GNTx=1 while the latched REQx stays high; the tenure counter increments each cycle.
REQ-020 OWNED: when REQx drops, go to RELEASE.
REQ-021 Tenure expiry: when the tenure counter reaches MAX_TENURE (MAX_TENURE≠0) and AS_IN=0, go to RELEASE and pulse TIMEOUT.
REQ-022 Tenure expiry with AS_IN=1: release SHALL be deferred until AS_IN=0.
REQ-023 RELEASE: BGACK=0 and GNT0=GNT1=0 for exactly one cycle, then go to IDLE. A requester still asserting REQ is re-arbitrated normally.
REQ-024 Withdrawal: if the latched REQ drops in REQUEST or WAIT_BUS, then BR=0, no grant is issued, no TIMEOUT pulse occurs, and the arbiter goes to IDLE.
REQ-025 RUN_IN=0 in REQUEST or WAIT_BUS SHALL abort identically to a withdrawal; RUN_IN SHALL be ignored in OWNED and RELEASE.
REQ-026 Simultaneous BG_IN and counter==BG_TIMEOUT in REQUEST: BG_IN wins, with no TIMEOUT pulse.
REQ-027 Simultaneous REQx drop and tenure expiry: go to RELEASE with no TIMEOUT pulse.
REQ-028 BR and BGACK SHALL never both be 1 for more than the single transition edge; BGACK SHALL rise on the same edge that BR falls.
REQ-029 A requester's REQ toggling while the other is OWNED SHALL have no effect on the grant.
REQ-030 Both counters SHALL saturate and never wrap.
REQ-031 Both counters SHALL clear on every state entry.

Reset
REQ-032 With RESET_n_IN=0 at a rising edge, the arbiter SHALL enter IDLE and drive BR=BGACK=GNT0=GNT1=BUSY=TIMEOUT=0.
REQ-033 Reset SHALL point the last-served pointer so requester 0 wins the first tie, and SHALL clear both counters.
REQ-034 Reset SHALL take precedence in any state, including mid-ownership; outputs SHALL drop on the same edge.
REQ-035 The arbiter SHALL be in IDLE on the first edge after RESET_n_IN returns to 1.

Verification
REQ-036 REQ0=1 at cycle 0, BG_IN=1 at cycle 3, AS_IN=DTACK_IN=0 -> BR=1 at cycle 1; WAIT_BUS at cycle 4; BGACK=1, GNT0=1, BR=0 at cycle 5; REQ0 drops at 10 -> RELEASE at 11, IDLE at 12.
REQ-037 REQ0 and REQ1 both held high continuously, BG_IN always 1 -> grants alternate GNT0, GNT1, GNT0, …, with one RELEASE cycle between tenures.
REQ-038 REQ1=1, BG_IN held 0, BG_TIMEOUT=255 -> BR high for exactly 255 cycles, then TIMEOUT pulses once, BR=0, state IDLE.
REQ-039 OWNED with REQ0 held, MAX_TENURE=16, AS_IN=1 at expiry and falling 3 cycles later -> RELEASE on the cycle after AS_IN=0, TIMEOUT pulses once.
REQ-040 RESET_n_IN=0 during OWNED -> BGACK, GNT0, BUSY=0 on the next edge; REQ0 and REQ1 both high after reset -> requester 0 wins.
